// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing stage: the vehicle light
// codes (identical to the ones traffic_control drives) and the controller
// state encoding.
package ped_pkg;

    // Vehicle light codes as driven by traffic_control
    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_BAD    = 2'b11;

    // Controller states; the encoding is visible on the dbg_state port
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WALK  = 3'd2,
        S_CLEAR = 3'd3,
        S_HOLD  = 3'd4,
        S_FAULT = 3'd5
    } ped_state_e;

    // Larger of two integers, used for sizing the tick counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_debounce.sv
// Push-button conditioning: two-flop synchroniser, a stable-high counter and
// a one-cycle press pulse on the rising edge of the debounced level. A held
// button produces exactly one pulse; a high pulse shorter than DEBOUNCE_CYC
// synchronised cycles never raises the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] stable_cnt;

    // Synchronise the raw button, count consecutive high cycles, track the debounced level
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            if (!sync2) begin
                stable_cnt <= '0;
                level      <= 1'b0;
            end else begin
                // Saturate so a long hold never wraps and re-triggers
                if (stable_cnt != CW'(DEBOUNCE_CYC)) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                // This cycle is the DEBOUNCE_CYC-th consecutive high sample
                if (stable_cnt >= CW'(DEBOUNCE_CYC - 1)) begin
                    level <= 1'b1;
                end
            end
        end
    end

    // One-cycle pulse when the debounced level rises
    assign press = level & ~level_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal stage downstream of traffic_control. Grants WALK only at
// the start of a fresh vehicle RED, runs a flashing clearance with a seconds
// countdown, aborts safely if the light leaves RED early and latches a sticky
// fault when the light code is illegal for two consecutive cycles.
//
// Interface note: there is no handshake; light and ped_btn are sampled every
// cycle and every output is a register updated on the rising clock edge.
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int TICK_DIV     = 10,
    parameter int DEBOUNCE_CYC = 4,
    parameter int WALK_SEC     = 7,
    parameter int FLASH_SEC    = 5,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault,
    output logic [2:0]       dbg_state
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int HALF  = TICK_DIV / 2;
    localparam int TC_W  = $clog2(max_int(WALK_SEC, FLASH_SEC) + 1);

    ped_state_e       state;
    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] pre_next;
    logic [TC_W-1:0]  tick_cnt;
    logic [1:0]       light_q;
    logic             tick;
    logic             red_edge;
    logic             not_red;
    logic             bad_twice;
    logic             press;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .btn  (ped_btn),
        .press(press)
    );

    // Previous-cycle light, used for RED edge detection and the two-cycle illegal check
    always_ff @(posedge clk) begin
        light_q <= light;
    end

    assign tick      = (prescaler == PRE_W'(TICK_DIV - 1));
    assign pre_next  = tick ? '0 : prescaler + 1'b1;
    assign red_edge  = (light == LIGHT_RED) && (light_q != LIGHT_RED);
    assign not_red   = (light != LIGHT_RED);
    assign bad_twice = (light == LIGHT_BAD) && (light_q == LIGHT_BAD);
    assign dbg_state = state;

    // Crossing FSM with prescaler, tick counter and registered head/countdown outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            prescaler   <= '0;
            tick_cnt    <= '0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= '0;
            req_pending <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // Free-running by default; cleared explicitly on entry to WALK and CLEAR
            prescaler <= pre_next;

            if (bad_twice) begin
                // Illegal code persists: outranks abort and red_edge
                state     <= S_FAULT;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                countdown <= '0;
                fault     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (press) begin
                            req_pending <= 1'b1;
                        end
                        if (req_pending) begin
                            state <= S_WAIT;
                        end
                    end

                    S_WAIT: begin
                        if (press) begin
                            req_pending <= 1'b1;
                        end
                        // Only a fresh RED serves the request, never one already running
                        if (red_edge) begin
                            state       <= S_WALK;
                            walk        <= 1'b1;
                            dont_walk   <= 1'b0;
                            req_pending <= 1'b0;
                            prescaler   <= '0;
                            tick_cnt    <= '0;
                        end
                    end

                    S_WALK: begin
                        // Presses while walking are deliberately ignored
                        if (not_red) begin
                            state       <= S_IDLE;
                            walk        <= 1'b0;
                            dont_walk   <= 1'b1;
                            countdown   <= '0;
                            req_pending <= 1'b1;
                        end else if (tick) begin
                            if (tick_cnt == TC_W'(WALK_SEC - 1)) begin
                                state     <= S_CLEAR;
                                walk      <= 1'b0;
                                dont_walk <= 1'b1;
                                countdown <= CNT_W'(FLASH_SEC);
                                prescaler <= '0;
                                tick_cnt  <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end

                    S_CLEAR: begin
                        if (press) begin
                            req_pending <= 1'b1;
                        end
                        if (not_red) begin
                            state       <= S_IDLE;
                            walk        <= 1'b0;
                            dont_walk   <= 1'b1;
                            countdown   <= '0;
                            req_pending <= 1'b1;
                        end else begin
                            // Flash: on for the first half of each second, off for the second half
                            dont_walk <= (pre_next < PRE_W'(HALF));
                            if (tick) begin
                                if (tick_cnt == TC_W'(FLASH_SEC - 1)) begin
                                    state     <= S_HOLD;
                                    dont_walk <= 1'b1;
                                    countdown <= '0;
                                    tick_cnt  <= '0;
                                end else begin
                                    tick_cnt  <= tick_cnt + 1'b1;
                                    countdown <= CNT_W'(FLASH_SEC - 1 - int'(tick_cnt));
                                end
                            end
                        end
                    end

                    S_HOLD: begin
                        if (press) begin
                            req_pending <= 1'b1;
                        end
                        // Wait out the rest of this RED so the next grant needs a new edge
                        if (not_red) begin
                            state <= S_IDLE;
                        end
                        dont_walk <= 1'b1;
                    end

                    S_FAULT: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= '0;
                        fault     <= 1'b1;
                    end

                    default: begin
                        state     <= S_IDLE;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= '0;
                    end
                endcase
            end
        end
    end

endmodule
